// File: rtl/lru_ctrl.sv
// LRU replacement controller: arbitrates hit touches against miss victim lookups
// and sequences the command interface of an external LRU array.
//
// state  | meaning
// INIT   | one-cycle init-all command to the LRU array
// IDLE   | arbitrate flush / miss / hit requests
// LOOKUP | read the LRU way of the missing set into victim_q
// TOUCH  | report the victim and mark it most recently used
module lru_ctrl #(
    parameter int ASSOC        = 8,
    parameter int INDEX_SIZE   = 7,
    parameter int STARVE_LIMIT = 4,
    localparam int WAY_W       = $clog2(ASSOC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  hit_valid,
    output logic                  hit_ready,
    input  logic [INDEX_SIZE-1:0] hit_index,
    input  logic [WAY_W-1:0]      hit_way,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [INDEX_SIZE-1:0] miss_index,
    output logic                  victim_valid,
    output logic [WAY_W-1:0]      victim_way,
    output logic                  busy,
    output logic [1:0]            lru_replace,
    output logic [INDEX_SIZE-1:0] lru_index,
    output logic [WAY_W-1:0]      lru_assoc,
    input  logic [WAY_W-1:0]      lru_way
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    localparam logic [1:0] CMD_INIT  = 2'b00;
    localparam logic [1:0] CMD_TOUCH = 2'b01;
    localparam logic [1:0] CMD_NOP   = 2'b11;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_TOUCH} state_e;

    state_e                  state_q, state_d;
    logic [SW-1:0]           starve_q, starve_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [INDEX_SIZE-1:0]   idx_q, idx_d;
    logic [WAY_W-1:0]        victim_q, victim_d;
    logic                    starve_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            starve_q     <= '0;
            flush_pend_q <= 1'b0;
            idx_q        <= '0;
            victim_q     <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            flush_pend_q <= flush_pend_d;
            idx_q        <= idx_d;
            victim_q     <= victim_d;
        end
    end

    assign starve_sat = (starve_q == STARVE_MAX);
    assign busy       = (state_q != S_IDLE);
    assign victim_way = victim_q;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        flush_pend_d = flush_pend_q | flush;
        idx_d        = idx_q;
        victim_d     = victim_q;
        hit_ready    = 1'b0;
        miss_ready   = 1'b0;
        victim_valid = 1'b0;
        lru_replace  = CMD_NOP;
        lru_index    = '0;
        lru_assoc    = '0;

        if (!rst) begin
            case (state_q)
                S_INIT: begin
                    lru_replace = CMD_INIT;
                    state_d     = S_IDLE;
                end
                S_IDLE: begin
                    hit_ready  = !flush_pend_q && !(miss_valid && starve_sat);
                    miss_ready = !flush_pend_q && (!hit_valid || starve_sat);
                    if (flush_pend_q) begin
                        // a flush arriving on the same cycle stays pending for another init
                        flush_pend_d = flush;
                        state_d      = S_INIT;
                    end else if (miss_valid && miss_ready) begin
                        idx_d   = miss_index;
                        state_d = S_LOOKUP;
                    end else if (hit_valid && hit_ready) begin
                        lru_replace = CMD_TOUCH;
                        lru_index   = hit_index;
                        lru_assoc   = hit_way;
                        if (miss_valid && !starve_sat) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
                S_LOOKUP: begin
                    lru_index = idx_q;
                    victim_d  = lru_way;
                    state_d   = S_TOUCH;
                end
                S_TOUCH: begin
                    lru_replace  = CMD_TOUCH;
                    lru_index    = idx_q;
                    lru_assoc    = victim_q;
                    victim_valid = 1'b1;
                    state_d      = S_IDLE;
                end
                default: state_d = S_INIT;
            endcase

            if (!miss_valid || miss_ready) begin
                starve_d = '0;
            end
        end
    end

endmodule

// File: tb/tb_lru_ctrl.sv
// Bench for lru_ctrl: a cycle-level behavioural model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_lru_ctrl;

    localparam int ASSOC = 8;
    localparam int IW    = 7;
    localparam int WW    = 3;
    localparam int LIM   = 4;

    logic          clk = 1'b0;
    logic          rst, flush, hit_valid, miss_valid;
    logic [IW-1:0] hit_index, miss_index;
    logic [WW-1:0] hit_way;
    logic          hit_ready, miss_ready, victim_valid, busy;
    logic [WW-1:0] victim_way, lru_assoc, lru_way;
    logic [1:0]    lru_replace;
    logic [IW-1:0] lru_index;

    logic [WW-1:0] way_tbl [2**IW];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lru_ctrl #(.ASSOC(ASSOC), .INDEX_SIZE(IW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_index(hit_index), .hit_way(hit_way),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_index(miss_index),
        .victim_valid(victim_valid), .victim_way(victim_way), .busy(busy),
        .lru_replace(lru_replace), .lru_index(lru_index), .lru_assoc(lru_assoc),
        .lru_way(lru_way)
    );

    // LRU array stand-in: a fixed per-set "least recently used" way
    initial for (int i = 0; i < 2**IW; i++) way_tbl[i] = WW'((i + 6) % ASSOC);
    assign lru_way = way_tbl[lru_index];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: init pending, age of the miss in flight, flush pending, starvation run
    bit            m_init   = 1'b1;
    int            m_age    = 0;
    bit            m_fp     = 1'b0;
    int            m_starve = 0;
    logic [IW-1:0] m_idx    = '0;
    logic [WW-1:0] m_last   = '0;

    always @(negedge clk) begin : cmp
        logic          e_hr, e_mr, e_vv, e_busy, idle, sat, hhs, mhs;
        logic [1:0]    e_rep;
        logic [IW-1:0] e_idx;
        logic [WW-1:0] e_as, e_vw;
        e_hr = 1'b0; e_mr = 1'b0; e_vv = 1'b0; e_busy = 1'b1; idle = 1'b0;
        e_rep = 2'b11; e_idx = '0; e_as = '0; e_vw = m_last;
        if (rst) begin
        end else if (m_init) begin
            e_rep = 2'b00;
        end else if (m_age == 1) begin
            e_idx = m_idx;
        end else if (m_age == 2) begin
            e_rep = 2'b01; e_idx = m_idx; e_as = way_tbl[m_idx];
            e_vv = 1'b1; e_vw = way_tbl[m_idx];
        end else begin
            idle = 1'b1; e_busy = 1'b0;
            sat  = (m_starve == LIM);
            e_hr = !m_fp && !(miss_valid && sat);
            e_mr = !m_fp && (!hit_valid || sat);
            if (hit_valid && e_hr) begin
                e_rep = 2'b01; e_idx = hit_index; e_as = hit_way;
            end
        end
        hhs = hit_valid && e_hr;
        mhs = miss_valid && e_mr;

        check("m_hit_ready", 32'(hit_ready), 32'(e_hr));
        check("m_miss_ready", 32'(miss_ready), 32'(e_mr));
        check("m_victim_valid", 32'(victim_valid), 32'(e_vv));
        check("m_lru_replace", 32'(lru_replace), 32'(e_rep));
        check("m_lru_index", 32'(lru_index), 32'(e_idx));
        check("m_lru_assoc", 32'(lru_assoc), 32'(e_as));
        if (!rst) begin
            check("m_busy", 32'(busy), 32'(e_busy));
            check("m_victim_way", 32'(victim_way), 32'(e_vw));
        end

        if (rst) begin
            m_init = 1'b1; m_age = 0; m_fp = 1'b0; m_starve = 0; m_idx = '0; m_last = '0;
        end else begin
            if (!miss_valid || mhs) m_starve = 0;
            else if (idle && hhs && m_starve < LIM) m_starve = m_starve + 1;
            if (m_init) m_init = 1'b0;
            else if (m_age == 1) m_age = 2;
            else if (m_age == 2) begin m_age = 0; m_last = way_tbl[m_idx]; end
            else if (m_fp) begin m_init = 1'b1; m_fp = 1'b0; end
            else if (mhs) begin m_age = 1; m_idx = miss_index; end
            if (flush) m_fp = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hit_valid = 1'b0; miss_valid = 1'b0;
        hit_index = '0; hit_way = '0; miss_index = '0;
        repeat (3) step();
        sample();
        check("rst_replace", 32'(lru_replace), 32'h3);
        check("rst_hit_ready", 32'(hit_ready), 32'h0);
        check("rst_miss_ready", 32'(miss_ready), 32'h0);
        step(); rst = 1'b0;
        sample();
        check("init_replace", 32'(lru_replace), 32'h0);
        check("init_busy", 32'(busy), 32'h1);
        step(); sample();
        check("idle_hit_ready", 32'(hit_ready), 32'h1);
        check("idle_miss_ready", 32'(miss_ready), 32'h1);
        check("idle_busy", 32'(busy), 32'h0);

        // plain hits
        step(); hit_valid = 1'b1; hit_index = 7'd9; hit_way = 3'd2;
        sample();
        check("hit_replace", 32'(lru_replace), 32'h1);
        check("hit_index", 32'(lru_index), 32'd9);
        check("hit_assoc", 32'(lru_assoc), 32'd2);
        step(); hit_index = 7'd100; hit_way = 3'd7;
        step(); hit_valid = 1'b0;

        // miss on set 5 with a hit arriving while the miss is in flight
        miss_valid = 1'b1; miss_index = 7'd5;
        sample(); check("miss_accept", 32'(miss_ready), 32'h1);
        step(); miss_valid = 1'b0; hit_valid = 1'b1; hit_index = 7'd20; hit_way = 3'd1;
        sample();
        check("lookup_hit_ready", 32'(hit_ready), 32'h0);
        check("lookup_replace", 32'(lru_replace), 32'h3);
        check("lookup_index", 32'(lru_index), 32'd5);
        step(); sample();
        check("touch_vvalid", 32'(victim_valid), 32'h1);
        check("touch_vway", 32'(victim_way), 32'd3);
        check("touch_replace", 32'(lru_replace), 32'h1);
        check("touch_index", 32'(lru_index), 32'd5);
        check("touch_assoc", 32'(lru_assoc), 32'd3);
        check("touch_hit_ready", 32'(hit_ready), 32'h0);
        step(); sample();
        check("post_hit_ready", 32'(hit_ready), 32'h1);
        check("post_hit_index", 32'(lru_index), 32'd20);
        step(); hit_valid = 1'b0;

        // starvation: four hit grants then the miss wins
        hit_valid = 1'b1; miss_valid = 1'b1; miss_index = 7'd17; hit_index = 7'd33; hit_way = 3'd4;
        for (int i = 0; i < LIM; i++) begin
            sample();
            check("starve_hit_grant", 32'(hit_ready), 32'h1);
            check("starve_miss_wait", 32'(miss_ready), 32'h0);
            step();
        end
        sample();
        check("starve_miss_grant", 32'(miss_ready), 32'h1);
        check("starve_hit_block", 32'(hit_ready), 32'h0);
        step(); miss_valid = 1'b0;
        step(); sample();
        check("starve_vway", 32'(victim_way), 32'd7);
        step(); miss_valid = 1'b1; miss_index = 7'd18;
        sample();
        check("starve_cleared_hit", 32'(hit_ready), 32'h1);
        check("starve_cleared_miss", 32'(miss_ready), 32'h0);
        step(); miss_valid = 1'b0; hit_valid = 1'b0;

        // flush during LOOKUP does not abort the miss
        miss_valid = 1'b1; miss_index = 7'd40;
        step(); miss_valid = 1'b0; flush = 1'b1;
        step(); flush = 1'b0;
        sample();
        check("flush_vvalid", 32'(victim_valid), 32'h1);
        check("flush_vway", 32'(victim_way), 32'd6);
        step(); sample();
        check("flush_pend_hit_ready", 32'(hit_ready), 32'h0);
        step(); sample();
        check("flush_init", 32'(lru_replace), 32'h0);
        step(); sample();
        check("flush_done_ready", 32'(hit_ready), 32'h1);

        // flush in IDLE alongside a hit
        step(); hit_valid = 1'b1; hit_index = 7'd3; hit_way = 3'd5; flush = 1'b1;
        sample(); check("idle_flush_hit", 32'(lru_replace), 32'h1);
        step(); flush = 1'b0;
        sample(); check("idle_flush_block", 32'(hit_ready), 32'h0);
        step(); sample(); check("idle_flush_init", 32'(lru_replace), 32'h0);
        step(); sample(); check("idle_flush_resume", 32'(hit_ready), 32'h1);
        step(); hit_valid = 1'b0;

        // reset during TOUCH drops the victim
        miss_valid = 1'b1; miss_index = 7'd5;
        step(); miss_valid = 1'b0;
        step(); rst = 1'b1;
        sample();
        check("rst_touch_vvalid", 32'(victim_valid), 32'h0);
        check("rst_touch_replace", 32'(lru_replace), 32'h3);
        step(); sample(); check("rst_hold_replace", 32'(lru_replace), 32'h3);
        step(); rst = 1'b0;
        sample(); check("rst_touch_init", 32'(lru_replace), 32'h0);
        step(); sample(); check("rst_touch_idle", 32'(miss_ready), 32'h1);

        // pseudo-random traffic, checked by the model only
        for (int i = 0; i < 400; i++) begin
            step();
            rst        = ($urandom_range(0, 99) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            hit_valid  = ($urandom_range(0, 2) != 0);
            miss_valid = ($urandom_range(0, 2) == 0);
            hit_index  = IW'($urandom_range(0, 127));
            miss_index = IW'($urandom_range(0, 127));
            hit_way    = WW'($urandom_range(0, 7));
        end
        step();
        rst = 1'b0; flush = 1'b0; hit_valid = 1'b0; miss_valid = 1'b0;
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lru_ctrl.md
LRU_CTRL -- requirements
Module: lru_ctrl

Interface
REQ-001 SHALL have parameter ASSOC, default 8, meaning ways per set (power of two, >=2); WAY_W = $clog2(ASSOC).
REQ-002 SHALL have parameter INDEX_SIZE, default 7, meaning set-index width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive cycles a miss may lose arbitration to hits (>=1).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush  input  1  single-cycle pulse requesting re-initialisation of all LRU state.
REQ-007 SHALL have port hit_valid  input  1  hit-side touch request.
REQ-008 SHALL have port hit_ready  output  1  touch accepted this cycle when high together with hit_valid.
REQ-009 SHALL have port hit_index  input  INDEX_SIZE  set of the hit.
REQ-010 SHALL have port hit_way  input  WAY_W  way of the hit.
REQ-011 SHALL have port miss_valid  input  1  victim-selection request.
REQ-012 SHALL have port miss_ready  output  1  miss accepted this cycle when high together with miss_valid.
REQ-013 SHALL have port miss_index  input  INDEX_SIZE  set needing a victim.
REQ-014 SHALL have port victim_valid  output  1  one-cycle pulse; victim_way valid.
REQ-015 SHALL have port victim_way  output  WAY_W  selected victim way; held until the next victim_valid.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-017 SHALL have port lru_replace  output  2  LRU array command: 00 init all, 01 touch way, 11 no-op; 10 never driven.
REQ-018 SHALL have port lru_index  output  INDEX_SIZE  set index to the LRU array.
REQ-019 SHALL have port lru_assoc  output  WAY_W  way to touch.
REQ-020 SHALL have port lru_way  input  WAY_W  combinational LRU way of lru_index from the array.

Function
REQ-021 SHALL implement states INIT, IDLE, LOOKUP, TOUCH.
REQ-022 SHALL drive lru_replace=00 for exactly one cycle in INIT, then go to IDLE.
REQ-023 SHALL, in IDLE, evaluate in priority order: pending flush -> INIT; granted miss -> LOOKUP; granted hit -> stay IDLE.
REQ-024 SHALL set hit_ready = IDLE && !flush_pend && !(miss_valid && starve_cnt==STARVE_LIMIT).
REQ-025 SHALL set miss_ready = IDLE && !flush_pend && (!hit_valid || starve_cnt==STARVE_LIMIT).
REQ-026 SHALL, on a hit handshake, drive lru_replace=01, lru_index=hit_index, lru_assoc=hit_way combinationally in that same cycle.
REQ-027 SHALL, on a miss handshake, register miss_index into idx_q and enter LOOKUP next cycle.
REQ-028 SHALL, in LOOKUP, drive lru_index=idx_q, lru_replace=11, capture lru_way into victim_q, and enter TOUCH.
REQ-029 SHALL, in TOUCH, drive lru_replace=01, lru_index=idx_q, lru_assoc=victim_q, and pulse victim_valid with victim_way=victim_q; return to IDLE.
REQ-030 SHALL give a miss latency of exactly 2 cycles (accepted at T, victim_valid at T+2), with the next request accepted no earlier than T+3.
REQ-031 SHALL drive lru_replace=11 and lru_index/lru_assoc=0 in any cycle with no command.
REQ-032 SHALL manage starve_cnt (width $clog2(STARVE_LIMIT+1)) as follows: +1 when miss_valid && !miss_ready in IDLE due to a hit grant; saturate at STARVE_LIMIT; clear on miss handshake or when miss_valid is low.
REQ-033 SHALL set flush_pend on flush in any state and clear it when entering INIT; a flush in LOOKUP/TOUCH SHALL NOT abort the miss in flight.
REQ-034 SHALL treat flush and rst in the same cycle as rst only.

Reset
REQ-035 SHALL, while rst is high, force state=INIT, starve_cnt=0, flush_pend=0, idx_q=0, victim_q=0, victim_valid=0, hit_ready=0, miss_ready=0, lru_replace=11.
REQ-036 SHALL drive lru_replace=00 in the first cycle after rst deasserts; busy=1 in that cycle, 0 from the next.
REQ-037 SHALL, on rst during LOOKUP/TOUCH, drop the miss with no victim_valid.

Verification
REQ-038 SHALL cover the following: rst released -> one cycle lru_replace=00, then IDLE with hit_ready=1 and miss_ready=1.
REQ-039 SHALL cover the following: miss_valid, miss_index=5, array lru_way=3 -> victim_valid at T+2 with victim_way=3, TOUCH drives index 5, assoc 3.
REQ-040 SHALL cover the following: hit_valid and miss_valid held high, STARVE_LIMIT=4 -> 4 hit grants, then miss granted on the 5th cycle, starve_cnt back to 0.
REQ-041 SHALL cover the following: flush pulsed in LOOKUP -> victim_valid still issued, then one INIT cycle (lru_replace=00) before the next grant.
REQ-042 SHALL cover the following: hit_valid asserted during LOOKUP/TOUCH -> hit_ready=0, no lru_replace=01 with hit_index until IDLE.
REQ-043 SHALL cover the following: rst asserted in TOUCH -> no victim_valid, lru_replace=11 during rst, INIT afterwards.
